// File: rtl/pixel_denoiser.sv
// 3x3 majority-style denoiser for a 1-bit colour mask, one pixel per accepted cycle, 1-cycle latency.
// Optional macro DENOISE_CENTER_REQ_EN additionally requires the centre tap to be set.
module pixel_denoiser #(
   parameter int IMG_WIDTH = 640,
   parameter int THRESH    = 5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pix_valid,
   input  logic        bin_in,
   input  logic [12:0] row,
   input  logic [12:0] col,
   input  logic        V_sync,
   output logic        out_img,
   output logic [12:0] out_row,
   output logic [12:0] out_col,
   output logic        out_valid
);

   localparam int          AW         = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
   localparam logic [12:0] WIDTH_LIM  = 13'(IMG_WIDTH);
   localparam logic [3:0]  THRESH_CNT = 4'(THRESH);

   logic          line_r1 [IMG_WIDTH];
   logic          line_r2 [IMG_WIDTH];
   logic [AW-1:0] addr;
   logic          accept;
   logic          emit;
   logic [2:0]    new_col;
   logic [2:0]    win_c1;
   logic [2:0]    win_c2;
   logic [2:0]    row_mask;
   logic [8:0]    taps;
   logic [3:0]    count;
   logic          hit;

   assign addr    = col[AW-1:0];
   assign accept  = !reset && pix_valid && !V_sync && (col < WIDTH_LIM);
   assign emit    = (row != 13'd0) && (col != 13'd0);
   // Column bit order is {row r, row r-1, row r-2}.
   assign new_col = {bin_in, line_r1[addr], line_r2[addr]};

   // NOTE: line buffers are plain RAM with no reset; row/column masking below keeps stale entries out of the count.
   always_ff @(posedge clk) begin
      if (accept) begin
         line_r1[addr] <= bin_in;
         line_r2[addr] <= line_r1[addr];
      end
   end

   // Stored columns always come from the current row, so the current row index masks all three.
   // NOTE: every signal assigned in always_comb gets a value on every path to avoid inferring latches.
   always_comb begin
      row_mask = {1'b1, row != 13'd0, row > 13'd1};
      taps     = {new_col & row_mask,
                  (col != 13'd0) ? (win_c1 & row_mask) : 3'b000,
                  (col >  13'd1) ? (win_c2 & row_mask) : 3'b000};
      count    = 4'd0;
      for (int i = 0; i < 9; i++) begin
         count = count + {3'b000, taps[i]};
      end
`ifdef DENOISE_CENTER_REQ_EN
      hit = (count >= THRESH_CNT) && win_c1[1];
`else
      hit = (count >= THRESH_CNT);
`endif
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         win_c1    <= 3'b000;
         win_c2    <= 3'b000;
         out_img   <= 1'b0;
         out_row   <= 13'd0;
         out_col   <= 13'd0;
         out_valid <= 1'b0;
      end else if (V_sync) begin
         win_c1    <= 3'b000;
         win_c2    <= 3'b000;
         out_valid <= 1'b0;
      end else if (accept) begin
         win_c2    <= win_c1;
         win_c1    <= new_col;
         out_valid <= emit;
         if (emit) begin
            out_row <= row - 13'd1;
            out_col <= col - 13'd1;
            out_img <= hit;
         end
      end else begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pixel_denoiser.sv
// Scoreboard bench for pixel_denoiser: a frame-image model predicts every output cycle.
module tb_pixel_denoiser;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        pix_valid = 1'b0;
   logic        bin_in = 1'b0;
   logic [12:0] row = '0;
   logic [12:0] col = '0;
   logic        V_sync = 1'b0;
   logic        out_img;
   logic [12:0] out_row;
   logic [12:0] out_col;
   logic        out_valid;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      string       tag;
      bit          full;
      bit          valid;
      logic [12:0] row;
      logic [12:0] col;
      bit          img;
   } exp_t;

   exp_t sb[$];
   bit   img [64][640];

   pixel_denoiser #(.IMG_WIDTH(640), .THRESH(5)) dut (
      .clk(clk), .reset(reset), .pix_valid(pix_valid), .bin_in(bin_in),
      .row(row), .col(col), .V_sync(V_sync),
      .out_img(out_img), .out_row(out_row), .out_col(out_col), .out_valid(out_valid)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", sb.size());
      $fatal(1, "watchdog");
   end

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: count set pixels of the 3x3 neighbourhood ending at (r,c), off-image counts as 0.
   function automatic bit model(int r, int c);
      int cnt = 0;
      bit res;
      for (int dr = 0; dr < 3; dr++)
         for (int dc = 0; dc < 3; dc++)
            if (r - dr >= 0 && c - dc >= 0) cnt += int'(img[r-dr][c-dc]);
      res = (cnt >= 5);
`ifdef DENOISE_CENTER_REQ_EN
      res = res && img[r-1][c-1];
`endif
      return res;
   endfunction

   task automatic drive(bit rst, bit pv, bit vs, bit b, int r, int c, string tag);
      exp_t e;
      @(negedge clk);
      reset     = rst;
      pix_valid = pv;
      V_sync    = vs;
      bin_in    = b;
      row       = 13'(r);
      col       = 13'(c);
      e.tag   = tag;
      e.full  = rst;
      e.valid = 1'b0;
      e.row   = '0;
      e.col   = '0;
      e.img   = 1'b0;
      if (!rst && pv && !vs && c < 640) begin
         img[r][c] = b;
         if (r >= 1 && c >= 1) begin
            e.valid = 1'b1;
            e.row   = 13'(r - 1);
            e.col   = 13'(c - 1);
            e.img   = model(r, c);
         end
      end
      sb.push_back(e);
   endtask

   task automatic idle(string tag);
      drive(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 8191)), int'($urandom_range(0, 8191)), tag);
   endtask

   task automatic vsync_pulse(string tag);
      repeat (2) drive(1'b0, 1'b1, 1'b1, 1'b1, 5, 5, tag);
   endtask

   function automatic bit pix(int mode, int r, int c);
      case (mode)
         0: return 1'b1;
         1: return (r == 10 && c == 10);
         2: return (r >= 20 && r <= 22 && c >= 30 && c <= 32);
         3: return (r >= 5 && r <= 7 && c >= 5 && c <= 7 && !(r == 6 && c == 6));
         default: return 1'($urandom_range(0, 1));
      endcase
   endfunction

   // Streams rows 0..rows-1, cols 0..w-1; optional idle gaps and out-of-range pixels mid-row.
   task automatic frame(int mode, int rows, int w, bit gap, bit wide_junk, string tag);
      for (int r = 0; r < rows; r++) begin
         for (int c = 0; c < w; c++) begin
            if (wide_junk && c == w / 2)
               drive(1'b0, 1'b1, 1'b0, 1'b1, r, 700 + r, {tag, "_oob"});
            drive(1'b0, 1'b1, 1'b0, pix(mode, r, c), r, c, tag);
            if (gap) idle({tag, "_gap"});
         end
      end
      vsync_pulse({tag, "_vs"});
   endtask

   always @(posedge clk) begin
      #1;
      if (sb.size() != 0) begin
         exp_t e;
         e = sb.pop_front();
         check({e.tag, "_valid"}, 32'(out_valid), 32'(e.valid));
         if (e.valid || e.full) begin
            check({e.tag, "_row"}, 32'(out_row), 32'(e.row));
            check({e.tag, "_col"}, 32'(out_col), 32'(e.col));
            check({e.tag, "_img"}, 32'(out_img), 32'(e.img));
         end
      end
   end

   initial begin
      // Reset wins over an active pixel.
      repeat (3) drive(1'b1, 1'b1, 1'b0, 1'b1, 3, 3, "reset");
      frame(0, 4, 640, 1'b0, 1'b0, "ones");
      frame(1, 13, 24, 1'b0, 1'b0, "isolated");
      frame(2, 24, 40, 1'b0, 1'b0, "block");
      frame(2, 24, 40, 1'b1, 1'b0, "block_gapped");
      frame(3, 9, 12, 1'b0, 1'b0, "ring");
      frame(4, 6, 64, 1'b0, 1'b1, "random_oob");

      // Frame cut by V_sync mid-line at col 100, then a fresh frame.
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < ((r == 3) ? 100 : 128); c++)
            drive(1'b0, 1'b1, 1'b0, pix(4, r, c), r, c, "cut");
      repeat (2) drive(1'b0, 1'b1, 1'b1, 1'b1, 3, 100, "cut_vs");
      frame(4, 4, 48, 1'b0, 1'b0, "after_cut");

      // Random frame interrupted by reset at (50,200), then a clean all-ones frame.
      for (int r = 0; r <= 50; r++)
         for (int c = 0; c < ((r == 50) ? 200 : 256); c++)
            drive(1'b0, 1'b1, 1'b0, pix(4, r, c), r, c, "pre_reset");
      repeat (2) drive(1'b1, 1'b1, 1'b0, 1'b1, 50, 200, "mid_reset");
      frame(0, 4, 640, 1'b0, 1'b0, "ones_after_reset");

      repeat (4) idle("drain");
      repeat (3) @(posedge clk);
      #2;
      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pixel_denoiser.md
PIXEL_DENOISER -- requirements
Module: pixel_denoiser

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 640, meaning active pixels per line.
REQ-002 SHALL have parameter THRESH, default 5, meaning the minimum set-pixel count (of 9) for an output of 1.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-005 SHALL have port pix_valid, input, 1 bit, qualifying bin_in, row and col this cycle.
REQ-006 SHALL have port bin_in, input, 1 bit, the colour-classifier mask pixel (1 = paddle colour).
REQ-007 SHALL have ports row and col, input, 13 bits each, giving the coordinates of bin_in.
REQ-008 SHALL have port V_sync, input, 1 bit, the frame boundary marker; high for one or more cycles between frames.
REQ-009 SHALL have port out_img, output, 1 bit, the filtered mask pixel feeding the paddle tracker.
REQ-010 SHALL have ports out_row and out_col, output, 13 bits each, giving the coordinates of out_img.
REQ-011 SHALL have port out_valid, output, 1 bit, qualifying out_img, out_row and out_col.

Function
REQ-012 SHALL hold two 1-bit line buffers of IMG_WIDTH entries, storing rows r-1 and r-2, addressed by col.
REQ-013 SHALL, on an accepted pixel (pix_valid=1, V_sync=0, col<IMG_WIDTH), read both buffers at col, then write bin_in to the row r-1 buffer and the old row r-1 value to the row r-2 buffer.
REQ-014 SHALL keep a 3x3 window shift register of three columns; each accepted pixel shifts in the column {bin_in, buf r-1, buf r-2}.
REQ-015 SHALL treat window taps whose row index (row-1, row-2) or column index (col-1, col-2) is negative as 0, regardless of stored contents.
REQ-016 SHALL, for an accepted pixel at (r,c) with r>=1 and c>=1, evaluate the window centred on (r-1,c-1) and drive out_valid=1, out_row=r-1, out_col=c-1 on the next rising edge (latency 1 cycle).
REQ-017 SHALL compute out_img = 1 when the count of set taps (4-bit, 0..9) is >= THRESH; otherwise 0.
REQ-018 SHALL drive out_valid=0 on the cycle after any cycle with no accepted pixel, or an accepted pixel with r=0 or c=0.
REQ-019 SHALL ignore pixels with col>=IMG_WIDTH: no buffer write, no shift, and out_valid=0.
REQ-020 SHALL hold window contents unchanged while pix_valid=0, so gapped input within a line produces the same outputs as gapless input.
REQ-021 SHALL, while V_sync=1, clear the window to 0, accept no pixel, and drive out_valid=0 on the next cycle; V_sync has priority over pix_valid.
REQ-022 SHALL never emit the last image row or column as a centre pixel; the downstream tracker accepts this 1-pixel loss.

Reset
REQ-023 SHALL, while reset=1 at a clock edge, set out_img=0, out_row=0, out_col=0, out_valid=0, and clear the window; reset has priority over V_sync and pix_valid.
REQ-024 SHALL leave line buffer contents unreset; REQ-015 masking guarantees stale data is never used after reset or mid-frame reset.
REQ-025 SHALL resume normal filtering on the first accepted pixel after reset deasserts, with no extra idle cycles.

Configuration
REQ-026 SHALL recognise macro DENOISE_CENTER_REQ_EN; when defined, out_img = (count>=THRESH) AND centre tap; when undefined, out_img = (count>=THRESH) only, with no centre-tap logic present.

Verification
REQ-027 SHALL pass: reset, then a full 640-wide frame of all-1 mask, THRESH=5 -> out_img=1 for all interior centres; (0,0) centre count=4 -> out_img=0; (0,5) centre count=6 -> out_img=1.
REQ-028 SHALL pass: isolated single 1 at (10,10) in a zero frame -> every emitted out_img=0; with input at (11,11), out_valid=1 and out_row=10, out_col=10 one cycle later.
REQ-029 SHALL pass: 3x3 block of 1s at rows 20-22, cols 30-32 -> out_img=1 only at centres (20..22,30..32) where count>=5, i.e. (21,31) count 9 and edge-centres count 6, with corner-centres count 4 giving 0.
REQ-030 SHALL pass: the same frame streamed with pix_valid low every other cycle -> identical (out_row, out_col, out_img) sequence as gapless input.
REQ-031 SHALL pass: V_sync pulse mid-line at col=100, then a new frame starting at row 0 -> no out_valid during V_sync, and row 0 and col 0 of the new frame yield out_valid=0.
REQ-032 SHALL pass: reset asserted mid-frame at (50,200), then an all-1 frame -> outputs equal to a clean all-1 run, with no stale-buffer influence; with DENOISE_CENTER_REQ_EN defined, a ring of 8 ones around a 0 gives out_img=0 (undefined gives 1).
